pipe_stall_ctrl: RTL and testbench

Sequential stall/flush controller for the 5-stage MIPS pipeline. It sits beside the ID stage and drives the PC, IF/ID and ID/EX control-mux enables. It combines three sources into one prioritised stall sequence:
- load-use data hazards (one-cycle bubble);
- branch resolution (multi-cycle stall with conditional IF/ID flush);
- a global freeze while data memory is busy.

It also keeps a saturating stall-cycle counter for performance measurement.

---
 rtl/pipe_stall_ctrl.sv | 130 +++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stall_ctrl
// Description : Prioritised stall/flush controller for the 5-stage pipeline:
//               memory freeze > load-use bubble > branch resolution wait,
//               plus a saturating stall-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stall_ctrl #(
    parameter int BR_STALL = 2,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             IDEXMemRead,
    input  logic [4:0]       IDEXRegisterRt,
    input  logic [4:0]       IFIDRegisterRs,
    input  logic [4:0]       IFIDRegisterRt,
    input  logic             IFIDUsesRt,
    input  logic             ControlBranch,
    input  logic             BranchTaken,
    input  logic             MemBusy,
    input  logic             StatClr,
    output logic             PCstall,
    output logic             IFIDstall,
    output logic             controlmux,
    output logic             IFIDflush,
    output logic             PipeFreeze,
    output logic             State,
    output logic [CNT_W-1:0] StallCount
);

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        BRWAIT = 1'b1
    } state_t;

    localparam logic [2:0] c_brInit = 3'(BR_STALL - 1);

    state_t           r_state;
    state_t           w_stateNext;
    logic [2:0]       r_cnt;
    logic [2:0]       w_cntNext;
    logic [CNT_W-1:0] r_stallCount;
    logic             w_loadUse;
    logic             w_pcStall;
    logic             w_ifidStall;
    logic             w_controlMux;
    logic             w_ifidFlush;
    logic             w_pipeFreeze;

    assign w_loadUse = IDEXMemRead && (IDEXRegisterRt != 5'd0) &&
                       ((IDEXRegisterRt == IFIDRegisterRs) ||
                        (IFIDUsesRt && (IDEXRegisterRt == IFIDRegisterRt)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
        end
    end

    always_comb begin
        w_stateNext  = r_state;
        w_cntNext    = r_cnt;
        w_pcStall    = 1'b0;
        w_ifidStall  = 1'b0;
        w_controlMux = 1'b0;
        w_ifidFlush  = 1'b0;
        w_pipeFreeze = 1'b0;
        if (MemBusy) begin
            // Whole pipeline holds; the branch countdown pauses with it.
            w_pcStall    = 1'b1;
            w_ifidStall  = 1'b1;
            w_pipeFreeze = 1'b1;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_loadUse) begin
                        w_pcStall    = 1'b1;
                        w_ifidStall  = 1'b1;
                        w_controlMux = 1'b1;
                    end else if (ControlBranch) begin
                        // Branch itself proceeds into EX; fetch is held behind it.
                        w_pcStall   = 1'b1;
                        w_ifidStall = 1'b1;
                        w_cntNext   = c_brInit;
                        w_stateNext = BRWAIT;
                    end
                end
                BRWAIT: begin
                    w_controlMux = 1'b1;
                    if (r_cnt != 3'd0) begin
                        w_pcStall   = 1'b1;
                        w_ifidStall = 1'b1;
                        w_cntNext   = r_cnt - 3'd1;
                    end else begin
                        w_ifidFlush = BranchTaken;
                        w_stateNext = RUN;
                    end
                end
                default: w_stateNext = RUN;
            endcase
        end
    end

    // Outputs are forced low for the whole time reset is asserted.
    assign PCstall    = rst_n & w_pcStall;
    assign IFIDstall  = rst_n & w_ifidStall;
    assign controlmux = rst_n & w_controlMux;
    assign IFIDflush  = rst_n & w_ifidFlush;
    assign PipeFreeze = rst_n & w_pipeFreeze;
    assign State      = r_state;
    assign StallCount = r_stallCount;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stallCount <= '0;
        end else if (StatClr) begin
            r_stallCount <= '0;
        end else if (w_pcStall && (r_stallCount != {CNT_W{1'b1}})) begin
            r_stallCount <= r_stallCount + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
`default_nettype none
// Testbench for pipe_stall_ctrl: directed vector table, corner sequences and
// randomized traffic against a cycle-count reference model, three configurations.
module tb_pipe_stall_ctrl;

    typedef struct {
        logic       memRead;
        logic [4:0] exRt;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       usesRt;
        logic       br;
        logic       taken;
        logic       busy;
        logic       clr;
    } in_t;

    // exp bits: {PCstall, IFIDstall, controlmux, IFIDflush, PipeFreeze, State}
    typedef struct {
        in_t         i;
        logic [5:0]  exp;
        logic [15:0] expCnt;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        memRead, usesRt, br, taken, busy, clr;
    logic [4:0]  exRt, rs, rt;
    logic [2:0]  pcS, ifS, cmS, flS, frS, stS;
    logic [15:0] cA;
    logic [3:0]  cB, cC;

    int     nChecks = 0;
    int     nFail   = 0;
    int     cyc     = 0;
    bit     inBr [3];
    int     el   [3];
    longint mc   [3];
    int     brS  [3] = '{2, 1, 7};
    int     cw   [3] = '{16, 4, 4};

    pipe_stall_ctrl #(.BR_STALL(2), .CNT_W(16)) dutA (
        .clk(clk), .rst_n(rst_n), .IDEXMemRead(memRead), .IDEXRegisterRt(exRt),
        .IFIDRegisterRs(rs), .IFIDRegisterRt(rt), .IFIDUsesRt(usesRt),
        .ControlBranch(br), .BranchTaken(taken), .MemBusy(busy), .StatClr(clr),
        .PCstall(pcS[0]), .IFIDstall(ifS[0]), .controlmux(cmS[0]), .IFIDflush(flS[0]),
        .PipeFreeze(frS[0]), .State(stS[0]), .StallCount(cA));

    pipe_stall_ctrl #(.BR_STALL(1), .CNT_W(4)) dutB (
        .clk(clk), .rst_n(rst_n), .IDEXMemRead(memRead), .IDEXRegisterRt(exRt),
        .IFIDRegisterRs(rs), .IFIDRegisterRt(rt), .IFIDUsesRt(usesRt),
        .ControlBranch(br), .BranchTaken(taken), .MemBusy(busy), .StatClr(clr),
        .PCstall(pcS[1]), .IFIDstall(ifS[1]), .controlmux(cmS[1]), .IFIDflush(flS[1]),
        .PipeFreeze(frS[1]), .State(stS[1]), .StallCount(cB));

    pipe_stall_ctrl #(.BR_STALL(7), .CNT_W(4)) dutC (
        .clk(clk), .rst_n(rst_n), .IDEXMemRead(memRead), .IDEXRegisterRt(exRt),
        .IFIDRegisterRs(rs), .IFIDRegisterRt(rt), .IFIDUsesRt(usesRt),
        .ControlBranch(br), .BranchTaken(taken), .MemBusy(busy), .StatClr(clr),
        .PCstall(pcS[2]), .IFIDstall(ifS[2]), .controlmux(cmS[2]), .IFIDflush(flS[2]),
        .PipeFreeze(frS[2]), .State(stS[2]), .StallCount(cC));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic in_t mk(logic m, logic [4:0] e, logic [4:0] s, logic [4:0] t,
                               logic u, logic b, logic tk, logic bz, logic c);
        in_t r;
        r.memRead = m; r.exRt = e; r.rs = s; r.rt = t; r.usesRt = u;
        r.br = b; r.taken = tk; r.busy = bz; r.clr = c;
        return r;
    endfunction

    function automatic vec_t V(in_t i, logic [5:0] e, logic [15:0] c);
        vec_t r;
        r.i = i; r.exp = e; r.expCnt = c;
        return r;
    endfunction

    function automatic logic [5:0] outOf(int k);
        return {pcS[k], ifS[k], cmS[k], flS[k], frS[k], stS[k]};
    endfunction

    function automatic logic [15:0] cntOf(int k);
        if (k == 0) return cA;
        if (k == 1) return {12'd0, cB};
        return {12'd0, cC};
    endfunction

    function automatic bit isLoadUse(in_t i);
        return i.memRead && (i.exRt != 0) && ((i.exRt == i.rs) || (i.usesRt && (i.exRt == i.rt)));
    endfunction

    // Reference: a branch releases once BR_STALL unfrozen cycles have elapsed since acceptance.
    function automatic logic [5:0] mOut(int k, in_t i);
        if (!rst_n) return 6'b000000;
        if (i.busy) return {5'b11001, inBr[k]};
        if (!inBr[k]) begin
            if (isLoadUse(i)) return 6'b111000;
            if (i.br) return 6'b110000;
            return 6'b000000;
        end
        if (el[k] == brS[k]) return {3'b001, i.taken, 2'b01};
        return 6'b111001;
    endfunction

    task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s at cycle %0d: got %h want %h", nm, cyc, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input bit useExp);
        logic [5:0] e [3];
        memRead = v.i.memRead; exRt = v.i.exRt; rs = v.i.rs; rt = v.i.rt;
        usesRt = v.i.usesRt; br = v.i.br; taken = v.i.taken; busy = v.i.busy; clr = v.i.clr;
        #1;
        if (!rst_n) for (int k = 0; k < 3; k++) begin inBr[k] = 0; el[k] = 0; mc[k] = 0; end
        for (int k = 0; k < 3; k++) begin
            e[k] = mOut(k, v.i);
            chk($sformatf("model.out[%0d]", k), {10'd0, outOf(k)}, {10'd0, e[k]});
            chk($sformatf("model.cnt[%0d]", k), cntOf(k), 16'(mc[k]));
        end
        if (useExp) begin
            chk("vec.out", {10'd0, outOf(0)}, {10'd0, v.exp});
            chk("vec.cnt", cntOf(0), v.expCnt);
        end
        @(posedge clk);
        if (rst_n) begin
            for (int k = 0; k < 3; k++) begin
                if (v.i.clr) mc[k] = 0;
                else if (e[k][5] && mc[k] < ((64'sd1 << cw[k]) - 1)) mc[k]++;
                if (!v.i.busy) begin
                    if (!inBr[k]) begin
                        if (!isLoadUse(v.i) && v.i.br) begin inBr[k] = 1; el[k] = 1; end
                    end else if (el[k] == brS[k]) inBr[k] = 0;
                    else el[k]++;
                end
            end
        end
        cyc++;
        #1;
    endtask

    vec_t tbl [24];
    in_t  idle, lu;

    initial begin
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        lu   = mk(1, 5, 5, 0, 0, 0, 0, 0, 0);
        tbl[0]  = V(lu,                                  6'b111000, 16'd0);
        tbl[1]  = V(idle,                                6'b000000, 16'd1);
        tbl[2]  = V(mk(1, 0, 0, 0, 0, 0, 0, 0, 0),       6'b000000, 16'd1);
        tbl[3]  = V(mk(1, 7, 3, 7, 0, 0, 0, 0, 0),       6'b000000, 16'd1);
        tbl[4]  = V(mk(0, 9, 9, 9, 1, 0, 0, 0, 0),       6'b000000, 16'd1);
        tbl[5]  = V(mk(1, 7, 3, 7, 1, 0, 0, 0, 0),       6'b111000, 16'd1);
        tbl[6]  = V(mk(0, 0, 0, 0, 0, 1, 0, 0, 0),       6'b110000, 16'd2);
        tbl[7]  = V(mk(0, 0, 0, 0, 0, 0, 1, 0, 0),       6'b111001, 16'd3);
        tbl[8]  = V(mk(0, 0, 0, 0, 0, 0, 1, 0, 0),       6'b001101, 16'd4);
        tbl[9]  = V(idle,                                6'b000000, 16'd4);
        tbl[10] = V(mk(0, 0, 0, 0, 0, 1, 0, 0, 0),       6'b110000, 16'd4);
        tbl[11] = V(idle,                                6'b111001, 16'd5);
        tbl[12] = V(idle,                                6'b001001, 16'd6);
        tbl[13] = V(mk(1, 5, 5, 0, 0, 1, 0, 0, 0),       6'b111000, 16'd6);
        tbl[14] = V(mk(0, 0, 0, 0, 0, 1, 0, 0, 0),       6'b110000, 16'd7);
        tbl[15] = V(mk(0, 0, 0, 0, 0, 0, 1, 1, 0),       6'b110011, 16'd8);
        tbl[16] = V(mk(0, 0, 0, 0, 0, 0, 1, 1, 0),       6'b110011, 16'd9);
        tbl[17] = V(mk(0, 0, 0, 0, 0, 0, 1, 1, 0),       6'b110011, 16'd10);
        tbl[18] = V(mk(0, 0, 0, 0, 0, 0, 1, 0, 0),       6'b111001, 16'd11);
        tbl[19] = V(mk(0, 0, 0, 0, 0, 0, 1, 0, 0),       6'b001101, 16'd12);
        tbl[20] = V(mk(0, 0, 0, 0, 0, 1, 0, 0, 0),       6'b110000, 16'd12);
        tbl[21] = V(idle,                                6'b111001, 16'd13);
        tbl[22] = V(mk(0, 0, 0, 0, 0, 0, 0, 0, 1),       6'b001001, 16'd14);
        tbl[23] = V(idle,                                6'b000000, 16'd0);

        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin inBr[k] = 0; el[k] = 0; mc[k] = 0; end
        @(posedge clk); #1;
        step(V(mk(1, 5, 5, 5, 1, 1, 1, 1, 0), 6'b000000, 16'd0), 1);
        rst_n = 1'b1;

        foreach (tbl[n]) step(tbl[n], 1);

        // Reset asserted in the middle of a branch wait: no flush afterwards.
        step(V(mk(0, 0, 0, 0, 0, 1, 1, 0, 0), 6'b110000, 16'd0), 1);
        rst_n = 1'b0;
        step(V(mk(0, 0, 0, 0, 0, 0, 1, 0, 0), 6'b000000, 16'd0), 1);
        rst_n = 1'b1;
        step(V(mk(0, 0, 0, 0, 0, 0, 1, 0, 0), 6'b000000, 16'd0), 1);

        // BR_STALL=1 instance releases in the cycle right after the branch.
        step(V(mk(0, 0, 0, 0, 0, 1, 1, 0, 0), 6'b110000, 16'd0), 1);
        chk("br1.release", {10'd0, outOf(1)}, 16'h000d);
        step(V(mk(0, 0, 0, 0, 0, 0, 1, 0, 0), 6'b111001, 16'd1), 1);
        for (int n = 0; n < 8; n++) step(V(idle, 6'b000000, 16'd0), 0);

        // Saturation of the 4-bit counters.
        step(V(mk(0, 0, 0, 0, 0, 0, 0, 0, 1), 6'b000000, 16'd0), 0);
        for (int n = 0; n < 20; n++) step(V(lu, 6'b111000, 16'(n)), 1);
        #1;
        chk("sat.cntB", {12'd0, cB}, 16'd15);
        chk("sat.cntC", {12'd0, cC}, 16'd15);
        step(V(mk(0, 0, 0, 0, 0, 0, 0, 0, 1), 6'b000000, 16'd20), 1);
        chk("clr.cntB", {12'd0, cB}, 16'd0);

        for (int n = 0; n < 3000; n++) begin
            in_t r;
            logic [4:0] a;
            a = 5'($urandom_range(0, 3));
            r = mk(($urandom_range(0, 1) == 1), a, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   ($urandom_range(0, 1) == 1), ($urandom_range(0, 4) == 0), ($urandom_range(0, 1) == 1),
                   ($urandom_range(0, 4) == 0), ($urandom_range(0, 40) == 0));
            rst_n = ($urandom_range(0, 99) != 0);
            step(V(r, 6'b000000, 16'd0), 0);
        end
        rst_n = 1'b1;
        step(V(idle, 6'b000000, 16'd0), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
`default_nettype wire
